upstream_axis_adp_mc: RTL and testbench

- Multi-channel, parametrised upstream adaptor. Reads events from NCH GEP event buffers and emits them as one AXI4-Stream.
- Each buffer holds a header word at address 0 (top pointer + BCID) followed by payload words at addresses 1..top.
- Channels are arbitrated round-robin. Output is decoupled by a small credit-managed FIFO so a stalled sink never corrupts reads.
- Sits between the per-channel event buffers and the downstream AXI-Stream interconnect.

---
 rtl/upstream_axis_adp_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_upstream_axis_adp_mc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upstream_axis_adp_mc.sv
`default_nettype none
//==============================================================================
// Module   : upstream_axis_adp_mc
// Desc     : Multi-channel event-buffer reader. Arbitrates NCH GEP event
//            buffers round-robin, reads header + payload words and emits each
//            event as one AXI4-Stream packet through a credit-managed FIFO.
// Revision : 1.0 - initial release
//==============================================================================
module upstream_axis_adp_mc #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int TID_W  = 11,
    parameter int NCH    = 4,
    parameter int FIFO_D = 4
) (
    input  logic                                      clk,
    input  logic                                      ARESETn,
    output logic [NCH-1:0]                            rd_en,
    output logic [NCH*ADDR_W-1:0]                     rd_addr,
    input  logic [NCH*DATA_W-1:0]                     rd_data,
    input  logic [NCH-1:0]                            rd_EvTID_ready,
    output logic [NCH-1:0]                            rd_EvTID_DONE,
    output logic                                      TVALID,
    input  logic                                      TREADY,
    output logic [DATA_W-1:0]                         TDATA,
    output logic [DATA_W/8-1:0]                       TSTRB,
    output logic [DATA_W/8-1:0]                       TKEEP,
    output logic                                      TLAST,
    output logic [TID_W-1:0]                          TID,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  TDEST,
    output logic [15:0]                               evt_cnt
);

    localparam int c_DEST_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int c_PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int c_OCC_W  = $clog2(FIFO_D + 1);
    localparam int c_STRB_W = DATA_W / 8;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_HDR    = 3'd1;
    localparam logic [2:0] c_ST_HCAP   = 3'd2;
    localparam logic [2:0] c_ST_STREAM = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;

    // Control state
    logic [2:0]          r_state;
    logic [c_DEST_W-1:0] r_grant;
    logic [c_DEST_W-1:0] r_rr;
    logic [NCH-1:0]      r_mask;
    logic [ADDR_W-1:0]   r_top;
    logic [TID_W-1:0]    r_tid;
    logic [ADDR_W:0]     r_addr;          // one extra bit so top = 2^ADDR_W-1 never wraps
    logic                r_inflight;      // a read was issued last cycle, data arrives now
    logic                r_inflight_last;
    logic [15:0]         r_evt_cnt;

    // Output FIFO
    logic [DATA_W-1:0]   r_fifo_data [FIFO_D];
    logic                r_fifo_last [FIFO_D];
    logic [c_PTR_W-1:0]  r_wp;
    logic [c_PTR_W-1:0]  r_rp;
    logic [c_OCC_W-1:0]  r_occ;

    // Combinational helpers
    logic [NCH-1:0]      w_eligible;
    logic                w_found;
    logic [c_DEST_W-1:0] w_pick;
    int                  w_idx;
    logic [DATA_W-1:0]   w_rdata;
    logic [ADDR_W-1:0]   w_hdr_top;
    logic [TID_W-1:0]    w_hdr_bcid;
    logic                w_top_zero;
    logic                w_credit;
    logic                w_issue;
    logic                w_issue_last;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_head_last;
    logic                w_pkt_done;
    logic                w_done_evt;
    logic [NCH-1:0]      w_grant_oh;

    assign w_eligible   = rd_EvTID_ready & ~r_mask;
    assign w_rdata      = rd_data[int'(r_grant)*DATA_W +: DATA_W];
    assign w_hdr_top    = w_rdata[ADDR_W-1:0];
    assign w_hdr_bcid   = w_rdata[ADDR_W+TID_W-1:ADDR_W];
    assign w_top_zero   = (r_state == c_ST_HCAP) && (w_hdr_top == '0);
    // Credit counts words already queued plus the one still coming back from the buffer
    assign w_credit     = (int'(r_occ) + int'(r_inflight)) < FIFO_D;
    assign w_issue      = (r_state == c_ST_STREAM) && w_credit;
    assign w_issue_last = (r_addr == {1'b0, r_top});
    assign w_valid      = (r_occ != '0);
    assign w_push       = r_inflight;
    assign w_pop        = w_valid && TREADY;
    assign w_head_last  = r_fifo_last[r_rp];
    assign w_pkt_done   = w_pop && w_head_last;
    assign w_done_evt   = w_pkt_done || w_top_zero;
    assign w_grant_oh   = NCH'(1) << r_grant;

    // Round-robin search: first eligible channel strictly after the last served one
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= NCH) begin
                w_idx = w_idx - NCH;
            end
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = c_DEST_W'(w_idx);
            end
        end
    end

    // Buffer read port: header read in HDR, payload reads while streaming with credit
    always_comb begin
        rd_en   = '0;
        rd_addr = '0;
        if (r_state == c_ST_HDR) begin
            rd_en[r_grant] = 1'b1;
        end else if (w_issue) begin
            rd_en[r_grant] = 1'b1;
            rd_addr[int'(r_grant)*ADDR_W +: ADDR_W] = r_addr[ADDR_W-1:0];
        end
    end

    assign rd_EvTID_DONE = w_done_evt ? w_grant_oh : '0;
    assign TVALID        = w_valid;
    assign TDATA         = w_valid ? r_fifo_data[r_rp] : '0;
    assign TLAST         = w_valid && w_head_last;
    assign TSTRB         = {c_STRB_W{w_valid}};
    assign TKEEP         = {c_STRB_W{w_valid}};
    assign TID           = r_tid;
    assign TDEST         = r_grant;
    assign evt_cnt       = r_evt_cnt;

    // Event sequencer: arbitration, header capture, payload read issue, packet drain
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state         <= c_ST_IDLE;
            r_grant         <= '0;
            r_rr            <= '0;
            r_mask          <= '0;
            r_top           <= '0;
            r_tid           <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_evt_cnt       <= '0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            // The buffer needs one cycle to drop ready after DONE; hide it meanwhile
            r_mask          <= w_done_evt ? w_grant_oh : '0;
            if (w_done_evt) begin
                r_rr <= r_grant;
            end
            if (w_pkt_done) begin
                r_evt_cnt <= r_evt_cnt + 16'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= c_ST_HDR;
                    end
                end
                c_ST_HDR: begin
                    r_state <= c_ST_HCAP;
                end
                c_ST_HCAP: begin
                    r_top   <= w_hdr_top;
                    r_tid   <= w_hdr_bcid;
                    r_addr  <= (ADDR_W+1)'(1);
                    r_state <= w_top_zero ? c_ST_IDLE : c_ST_STREAM;
                end
                c_ST_STREAM: begin
                    if (w_issue) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_issue_last) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_pkt_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == c_PTR_W'(FIFO_D - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == c_PTR_W'(FIFO_D - 1)) ? '0 : r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage: returned buffer word tagged with its end-of-event flag
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wp] <= w_rdata;
            r_fifo_last[r_wp] <= r_inflight_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_upstream_axis_adp_mc.sv
`default_nettype none
//==============================================================================
// Module   : tb_upstream_axis_adp_mc
// Desc     : Directed self-checking bench for upstream_axis_adp_mc with a
//            behavioural event-buffer model and an expected-beat queue.
// Revision : 1.0 - initial release
//==============================================================================
module tb_upstream_axis_adp_mc;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 10;
    localparam int TID_W  = 11;
    localparam int NCH    = 4;
    localparam int FIFO_D = 4;
    localparam int DEST_W = 2;

    logic                    clk = 1'b0;
    logic                    ARESETn;
    logic [NCH-1:0]          rd_en;
    logic [NCH*ADDR_W-1:0]   rd_addr;
    logic [NCH*DATA_W-1:0]   rd_data;
    logic [NCH-1:0]          rd_EvTID_ready;
    logic [NCH-1:0]          rd_EvTID_DONE;
    logic                    TVALID;
    logic                    TREADY;
    logic [DATA_W-1:0]       TDATA;
    logic [DATA_W/8-1:0]     TSTRB;
    logic [DATA_W/8-1:0]     TKEEP;
    logic                    TLAST;
    logic [TID_W-1:0]        TID;
    logic [DEST_W-1:0]       TDEST;
    logic [15:0]             evt_cnt;

    upstream_axis_adp_mc #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TID_W  (TID_W),
        .NCH    (NCH),
        .FIFO_D (FIFO_D)
    ) u_dut (
        .clk            (clk),
        .ARESETn        (ARESETn),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_EvTID_ready (rd_EvTID_ready),
        .rd_EvTID_DONE  (rd_EvTID_DONE),
        .TVALID         (TVALID),
        .TREADY         (TREADY),
        .TDATA          (TDATA),
        .TSTRB          (TSTRB),
        .TKEEP          (TKEEP),
        .TLAST          (TLAST),
        .TID            (TID),
        .TDEST          (TDEST),
        .evt_cnt        (evt_cnt)
    );

    always #5 clk = ~clk;

    // Event-buffer model
    int                  top_of  [NCH];
    logic [TID_W-1:0]    bcid_of [NCH];
    logic [DATA_W-1:0]   rdq     [NCH];
    logic [NCH-1:0]      arm;
    logic [NCH-1:0]      ready_r = '0;

    function automatic logic [DATA_W-1:0] word_at(int c, int a);
        logic [DATA_W-1:0] w;
        if (a == 0) begin
            w = {DATA_W{1'b1}};
            w[ADDR_W+TID_W-1:0] = {bcid_of[c], ADDR_W'(top_of[c])};
        end else begin
            w = {32'hC0DE0000 + 32'(c), 32'(a), 32'hFACE0000 + 32'(a), 32'(a) ^ (32'(c) << 12)};
        end
        return w;
    endfunction

    // Buffer read: data valid one cycle after rd_en
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rd_en[c]) rdq[c] <= word_at(c, int'(rd_addr[c*ADDR_W +: ADDR_W]));
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NCH; c++) rd_data[c*DATA_W +: DATA_W] = rdq[c];
    end

    // Buffer drops ready when its event is reported done
    always @(posedge clk) ready_r <= (ready_r & ~rd_EvTID_DONE) | arm;
    assign rd_EvTID_ready = ready_r;

    // Scoreboard
    typedef struct packed {
        logic              last;
        logic [TID_W-1:0]  tid;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t       expq[$];
    beat_t       e;
    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt [NCH];
    int          zero_done = 0;
    int          hs_cnt = 0;
    logic        stalled = 1'b0;
    logic [255:0] snap;

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] outs_vec();
        return 256'({TVALID, TLAST, TDATA, TKEEP, TSTRB, TID, TDEST,
                     rd_en, rd_EvTID_DONE, evt_cnt, rd_addr});
    endfunction

    task automatic push_pkt(int c);
        beat_t b;
        for (int a = 1; a <= top_of[c]; a++) begin
            b.last = (a == top_of[c]);
            b.tid  = bcid_of[c];
            b.dest = DEST_W'(c);
            b.data = word_at(c, a);
            expq.push_back(b);
        end
    endtask

    task automatic arm_ch(logic [NCH-1:0] m);
        arm = m;
        @(posedge clk);
        #1 arm = '0;
    endtask

    task automatic wait_done(int c, int n, int bound);
        for (int i = 0; i < bound && done_cnt[c] < n; i++) @(negedge clk);
        #1;
        chk($sformatf("done_ch%0d", c), 256'(done_cnt[c]), 256'(n));
    endtask

    // Bus monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (ARESETn) begin
            if (stalled) chk("stall_hold", 256'({TVALID, TLAST, TID, TDEST, TDATA}), snap);
            stalled = TVALID && !TREADY;
            snap    = 256'({1'b1, TLAST, TID, TDEST, TDATA});
            if (TVALID) chk("keep_strb", 256'({TKEEP, TSTRB}), 256'(32'hFFFF_FFFF));
            if (rd_en != '0) begin
                chk("rd_en_onehot", 256'($countones(rd_en)), 256'(1));
                chk("rd_en_ready", 256'(rd_en & ~rd_EvTID_ready), 256'(0));
            end
            if (TVALID && TREADY) begin
                hs_cnt++;
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 256'(hs_cnt), 256'(0));
                end else begin
                    e = expq.pop_front();
                    chk("beat", 256'({TLAST, TID, TDEST, TDATA}), 256'(e));
                end
                if (TLAST) chk("done_on_last", 256'(rd_EvTID_DONE), 256'(4'b0001 << TDEST));
                else       chk("no_done_mid", 256'(rd_EvTID_DONE), 256'(0));
            end else if (rd_EvTID_DONE != '0) begin
                zero_done++;
            end
            for (int c = 0; c < NCH; c++) if (rd_EvTID_DONE[c]) done_cnt[c]++;
        end else begin
            stalled = 1'b0;
        end
    end

    int first_v;
    int done_at;
    int base;
    int dc;

    initial begin
        ARESETn = 1'b0;
        TREADY  = 1'b1;
        arm     = '0;
        for (int c = 0; c < NCH; c++) begin
            top_of[c]   = 0;
            bcid_of[c]  = '0;
            done_cnt[c] = 0;
        end
        repeat (2) @(negedge clk);
        #1 chk("reset_outs", outs_vec(), 256'(0));
        ARESETn = 1'b1;
        repeat (2) @(negedge clk);

        // T1: single channel, latency and throughput
        top_of[1] = 5; bcid_of[1] = 11'h123;
        push_pkt(1);
        arm_ch(4'b0010);
        first_v = -1; done_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            #1;
            if (TVALID && first_v < 0) first_v = i;
            if (rd_EvTID_DONE[1] && done_at < 0) done_at = i;
            if (i == 2) chk("hdr_read", 256'({rd_en, rd_addr[19:10]}), 256'({4'b0010, 10'd0}));
            if (i == 4) chk("first_read", 256'({rd_en, rd_addr[19:10]}), 256'({4'b0010, 10'd1}));
        end
        chk("first_valid_cyc", 256'(first_v), 256'(6));
        chk("done_cyc", 256'(done_at), 256'(10));
        chk("done_ch1_t1", 256'(done_cnt[1]), 256'(1));
        chk("evt_cnt_t1", 256'(evt_cnt), 256'(1));

        // T2: three channels together, then two more (round-robin order)
        top_of[0] = 3; bcid_of[0] = 11'h010;
        top_of[2] = 3; bcid_of[2] = 11'h020;
        top_of[3] = 3; bcid_of[3] = 11'h030;
        push_pkt(2); push_pkt(3); push_pkt(0);
        arm_ch(4'b1101);
        wait_done(2, 1, 60);
        wait_done(3, 1, 60);
        wait_done(0, 1, 60);
        repeat (3) @(negedge clk);
        #1 chk("evt_cnt_t2a", 256'(evt_cnt), 256'(4));
        bcid_of[0] = 11'h0A0; bcid_of[2] = 11'h2A0;
        push_pkt(2); push_pkt(0);
        arm_ch(4'b0101);
        wait_done(2, 2, 60);
        wait_done(0, 2, 60);
        repeat (3) @(negedge clk);
        #1 chk("evt_cnt_t2b", 256'(evt_cnt), 256'(6));

        // T3: random backpressure
        top_of[3] = 8; bcid_of[3] = 11'h7FF;
        push_pkt(3);
        arm_ch(4'b1000);
        for (int i = 0; i < 300 && done_cnt[3] < 2; i++) begin
            @(posedge clk);
            #1 TREADY = 1'($urandom_range(0, 1));
        end
        TREADY = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("done_ch3_t3", 256'(done_cnt[3]), 256'(2));
        chk("evt_cnt_t3", 256'(evt_cnt), 256'(7));

        // T4: empty event on ch2, then ch3 served
        top_of[2] = 0; bcid_of[2] = 11'h055;
        top_of[3] = 2; bcid_of[3] = 11'h066;
        push_pkt(3);
        arm_ch(4'b1100);
        wait_done(2, 3, 40);
        wait_done(3, 3, 60);
        repeat (3) @(negedge clk);
        #1;
        chk("zero_done", 256'(zero_done), 256'(1));
        chk("evt_cnt_t4", 256'(evt_cnt), 256'(8));

        // T5: reset during beat 3 of 6
        top_of[1] = 6; bcid_of[1] = 11'h1AB;
        push_pkt(1);
        base = hs_cnt;
        dc   = done_cnt[1];
        arm_ch(4'b0010);
        for (int i = 0; i < 40 && !(hs_cnt == base + 3 && TVALID); i++) begin
            @(negedge clk);
            #1;
        end
        chk("beat3_seen", 256'(hs_cnt), 256'(base + 3));
        ARESETn = 1'b0;
        #1 chk("rst_mid_outs", outs_vec(), 256'(0));
        expq.delete();
        repeat (2) @(negedge clk);
        #1 chk("rst_no_done", 256'(done_cnt[1]), 256'(dc));
        ARESETn = 1'b1;
        push_pkt(1);
        wait_done(1, dc + 1, 60);
        repeat (3) @(negedge clk);
        #1 chk("evt_cnt_t5", 256'(evt_cnt), 256'(1));

        // T6: maximum event length
        top_of[0] = 1023; bcid_of[0] = 11'h3FF;
        push_pkt(0);
        arm_ch(4'b0001);
        wait_done(0, 3, 1200);
        repeat (3) @(negedge clk);
        #1;
        chk("evt_cnt_t6", 256'(evt_cnt), 256'(2));
        chk("q_empty", 256'(expq.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
